// File: rtl/simon_inv_key_sched.sv
// SIMON64/128 inverse key schedule: expands the master key forward to
// the last four round keys, then streams k[ROUNDS-1] down to k[0].
module simon_inv_key_sched #(
    parameter int ROUNDS = 44
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [31:0]  rk_data,
    output logic [5:0]   rk_idx,
    output logic         done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] EMIT   = 2'd2;

    localparam logic [31:0] C = 32'hFFFF_FFFC;
    localparam logic [61:0] Z3 =
        62'b11011011101011000110010111100000010010001010011100110100001111;
    // Padded to 64 bits so z[i] is simply Z64[~i] with a 6-bit index.
    localparam logic [63:0] Z64 = {Z3, 2'b00};

    localparam logic [5:0] EXP_LAST = 6'(ROUNDS - 5);
    localparam logic [5:0] IDX_LAST = 6'(ROUNDS - 1);

    logic [1:0]  state;
    logic [31:0] w0, w1, w2, w3;
    logic [5:0]  cnt;
    logic        done_q;
    logic [31:0] nxt_fwd;
    logic [31:0] nxt_bwd;
    logic        emit;

    function automatic logic [31:0] f_mix(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] t;
        t = {a[2:0], a[31:3]} ^ b;
        return t ^ {t[0], t[31:1]};
    endfunction

    function automatic logic [31:0] zword(input logic [5:0] i);
        return {31'd0, Z64[~i]};
    endfunction

    always_comb begin
        nxt_fwd = w0 ^ C ^ zword(cnt) ^ f_mix(w3, w1);
        nxt_bwd = '0;
        if (cnt >= 6'd4)
            nxt_bwd = w3 ^ C ^ zword(cnt - 6'd4) ^ f_mix(w2, w0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            w0     <= '0;
            w1     <= '0;
            w2     <= '0;
            w3     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w0    <= key[31:0];
                        w1    <= key[63:32];
                        w2    <= key[95:64];
                        w3    <= key[127:96];
                        cnt   <= '0;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    w0 <= w1;
                    w1 <= w2;
                    w2 <= w3;
                    w3 <= nxt_fwd;
                    if (cnt == EXP_LAST) begin
                        cnt   <= IDX_LAST;
                        state <= EMIT;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        w3  <= w2;
                        w2  <= w1;
                        w1  <= w0;
                        w0  <= nxt_bwd;
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data/index are forced to zero outside EMIT so idle outputs stay clean.
    assign emit     = (state == EMIT);
    assign busy     = (state != IDLE);
    assign rk_valid = emit;
    assign rk_data  = emit ? w3 : '0;
    assign rk_idx   = emit ? cnt : '0;
    assign done     = done_q;

endmodule
